serial_add_seq: RTL and testbench

Bit-serial add/subtract sequencer that time-shares one full-adder cell (half-adder pair plus OR carry merge) across a WIDTH-bit operation. It captures two operands on a start request, then feeds one bit pair per cycle, LSB first, through the cell with a registered carry. It assembles the result in a shift register and reports completion with a one-cycle done pulse. It sits between a requesting control unit and the shared adder cell, trading latency for area.

---
 rtl/serial_add_seq_if.sv | 34 +++
 rtl/serial_add_seq.sv | 144 ++++++++++++++
 tb/tb_serial_add_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq_if
// Description : Request/result bundle between a control unit (master) and
//               the bit-serial add/subtract sequencer (slave).
//               master drives : start, sub, a, b, cin
//               slave drives  : busy, done, sum, cout, ovf
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial add/subtract sequencer. One full-adder cell
//               (two half adders plus an OR carry merge) is time-shared
//               across a WIDTH-bit operation, LSB first, with a registered
//               carry. Result is assembled in a shift register.
// Ports       : clk    - system clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - serial_add_seq_if.slave
//                        in : start, sub, a, b, cin
//                        out: busy, done, sum, cout, ovf (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    serial_add_seq_if.slave     bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;     // carry into the MSB position
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Shared full-adder cell: half adder on the operand bits, second half
    // adder folds in the carry, OR merges the two partial carries.
    logic w_h1_s, w_h1_c, w_h2_c, w_s, w_c;

    always_comb begin
        w_h1_s = a_q[0] ^ b_q[0];
        w_h1_c = a_q[0] & b_q[0];
        w_s    = w_h1_s ^ carry_q;
        w_h2_c = w_h1_s & carry_q;
        w_c    = w_h1_c | w_h2_c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    // Subtract as a + ~b + 1; the +1 rides in on the carry.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = {w_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_c;
                if (cnt_q == C_MSB_IN) begin
                    cmsb_d = w_c;
                end
                if (cnt_q == C_LAST) begin
                    cout_d  = w_c;
                    ovf_d   = cmsb_q ^ w_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state so that no
        // output depends combinationally on the state decode.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Scoreboard bench for serial_add_seq (WIDTH=8). Stimulus
//               pushes hand-computed results; a negedge monitor pops and
//               compares on every done pulse, and checks accept-to-done
//               latency, busy length and back-to-back accept spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_chk       = 0;
    int   n_fail      = 0;
    int   ncyc        = 0;
    int   acc_total   = 0;
    int   done_total  = 0;
    int   busy_cnt    = 0;
    int   last_acc    = 0;
    bit   have_last   = 1'b0;
    bit   chk_spacing = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
    endtask

    // Monitor: accept detection, done checking, scoreboard pop.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.start && !bus.busy && !bus.done) begin
                if (chk_spacing && have_last)
                    chk("accept_spacing", ncyc - last_acc, 10);
                last_acc  = ncyc;
                have_last = 1'b1;
                acc_q.push_back(ncyc);
                busy_cnt  = 0;
                acc_total++;
            end
            if (bus.done) begin
                done_total++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
                end else begin
                    exp_t e;
                    int   t0;
                    e  = exp_q.pop_front();
                    t0 = acc_q.pop_front();
                    chk("sum",        bus.sum,  e.s);
                    chk("cout",       bus.cout, e.c);
                    chk("ovf",        bus.ovf,  e.o);
                    chk("latency",    ncyc - t0, 9);
                    chk("busy_len",   busy_cnt, 8);
                    chk("busy_in_done", bus.busy, 0);
                end
            end
        end
    end

    task automatic wait_acc(input int tgt, input string nm);
        int k;
        k = 0;
        while (acc_total < tgt && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (acc_total < tgt) timeout(nm);
        #1;
    endtask

    task automatic wait_done(input int tgt, input string nm);
        int k;
        k = 0;
        while (done_total < tgt && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (done_total < tgt) timeout(nm);
        #1;
    endtask

    // One operation: drive, push expectation, scramble inputs after accept.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tcin, input logic tsub,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        int at, dt;
        at = acc_total + 1;
        dt = done_total + 1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.cin   = tcin;
        bus.sub   = tsub;
        bus.start = 1'b1;
        exp_q.push_back('{s: es, c: ec, o: eo});
        wait_acc(at, "accept");
        bus.start = 1'b0;
        bus.a     = 8'h5A;
        bus.b     = 8'hC3;
        bus.cin   = ~tcin;
        bus.sub   = ~tsub;
        wait_done(dt, "done");
    endtask

    initial begin
        int at, dt;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum",  bus.sum,  0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf",  bus.ovf,  0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain adds, carry out, signed overflow.
        op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        // Subtracts: borrow, no borrow, signed overflow; cin ignored.
        op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        op(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
        op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Result held in IDLE after completion.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_sum",  bus.sum,  8'h7F);
        chk("hold_cout", bus.cout, 1);
        chk("hold_ovf",  bus.ovf,  1);
        @(posedge clk);
        #1;

        // Start pulse during RUN must be ignored.
        at = acc_total + 1;
        dt = done_total + 1;
        bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back('{s: 8'h03, c: 1'b0, o: 1'b0});
        wait_acc(at, "accept_run");
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(dt, "done_run");
        repeat (12) @(posedge clk);
        #1;
        chk("no_second_op", done_total, dt);

        // Start held high: -128 + -128 three times, accepts 10 cycles apart.
        have_last   = 1'b0;
        chk_spacing = 1'b1;
        at = acc_total + 3;
        dt = done_total + 3;
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (3) exp_q.push_back('{s: 8'h00, c: 1'b1, o: 1'b1});
        bus.start = 1'b1;
        wait_acc(at, "accept_held");
        bus.start   = 1'b0;
        chk_spacing = 1'b0;
        wait_done(dt, "done_held");

        // Reset in the middle of RUN aborts the operation.
        at = acc_total + 1;
        dt = done_total;
        bus.a = 8'hC3; bus.b = 8'h3C; bus.cin = 1'b1; bus.sub = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back('{s: 8'h00, c: 1'b1, o: 1'b0});
        wait_acc(at, "accept_abort");
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_sum",  bus.sum,  0);
        chk("abort_cout", bus.cout, 0);
        chk("abort_ovf",  bus.ovf,  0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", done_total, dt);

        op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
